// File: rtl/riscv_pkg.sv
// Shared types and constants for the risc-v-lite pipeline stages.
package riscv_pkg;

   localparam int XLEN = 32;

   // cwWB control-word bit positions
   localparam int CW_REGWRITE = 2;
   localparam int CW_WBSEL_HI = 1;
   localparam int CW_WBSEL_LO = 0;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_NPC  = 2'b10,
      WB_IMM  = 2'b11
   } wb_sel_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ld_fmt_e;

   typedef enum logic [1:0] {
      EXEC      = 2'b00,
      WAIT_LOAD = 2'b01,
      HOLD      = 2'b10
   } wb_state_e;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [4:0]      dest;
   } ld_entry_t;

endpackage

// File: rtl/load_align.sv
// Sub-word load alignment: shifts the addressed byte/half to bit 0 and extends it.
module load_align
   import riscv_pkg::*;
#(
   parameter int N = XLEN
) (
   input  logic [N-1:0] raw,
   input  logic [1:0]   offset,
   input  logic [2:0]   ld_fmt,
   output logic [N-1:0] aligned
);

   logic [N-1:0] byte_sh;
   logic [N-1:0] half_sh;

   assign byte_sh = raw >> {offset, 3'b000};
   assign half_sh = raw >> {offset[1], 4'b0000};

   // Unknown funct3 encodings fall through to a full-word load
   always_comb begin
      aligned = raw;
      case (ld_fmt)
         LB:      aligned = {{(N-8){byte_sh[7]}}, byte_sh[7:0]};
         LH:      aligned = {{(N-16){half_sh[15]}}, half_sh[15:0]};
         LBU:     aligned = {{(N-8){1'b0}}, byte_sh[7:0]};
         LHU:     aligned = {{(N-16){1'b0}}, half_sh[15:0]};
         default: aligned = raw;
      endcase
   end

endmodule

// File: rtl/writeback.sv
// WB stage: write-value select, load return buffering, load-wait stall and
// retire-once tracking across pipe_en holds.
module writeback
   import riscv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pipe_en,
   input  logic [2:0]   cwWB,
   input  logic [N-1:0] ALUin,
   input  logic [N-1:0] NPCin,
   input  logic [N-1:0] IMMin,
   input  logic [4:0]   Rdest_in,
   input  logic [2:0]   ldFmt,
   input  logic         load_valid,
   input  logic [N-1:0] loadData,
   input  logic [4:0]   loadDest,
   output logic         rf_we,
   output logic [4:0]   rf_waddr,
   output logic [N-1:0] rf_wdata,
   output logic         stallWB,
   output logic         err_ovf,
   output logic         err_tag
);

   wb_state_e  state, state_nxt;
   wb_sel_e    wb_sel;
   ld_entry_t  fifo [2];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;

   logic         is_load, buf_empty, buf_full, ld_avail;
   logic         retire, pop, bypass, push, push_ok, overflow;
   logic [N-1:0] ld_raw, ld_aligned, wb_val;
   logic [4:0]   ld_dest;

   assign wb_sel    = wb_sel_e'(cwWB[CW_WBSEL_HI:CW_WBSEL_LO]);
   assign is_load   = cwWB[CW_REGWRITE] && (wb_sel == WB_LOAD);
   assign buf_empty = (count == 2'd0);
   assign buf_full  = (count == 2'd2);
   assign ld_avail  = !buf_empty || load_valid;

   // Buffer head has priority; an empty buffer lets the live return through
   assign ld_raw  = buf_empty ? loadData : fifo[rd_ptr].data;
   assign ld_dest = buf_empty ? loadDest : fifo[rd_ptr].dest;

   always_comb begin
      retire    = 1'b0;
      stallWB   = 1'b0;
      state_nxt = state;
      case (state)
         EXEC, WAIT_LOAD: begin
            if (!is_load || ld_avail) begin
               retire    = 1'b1;
               state_nxt = pipe_en ? EXEC : HOLD;
            end else begin
               stallWB   = 1'b1;
               state_nxt = WAIT_LOAD;
            end
         end
         HOLD:    if (pipe_en) state_nxt = EXEC;
         default: state_nxt = EXEC;
      endcase
   end

   assign pop      = retire && is_load && !buf_empty;
   assign bypass   = retire && is_load && buf_empty && load_valid;
   assign push     = load_valid && !bypass;
   assign push_ok  = push && (!buf_full || pop);
   assign overflow = push && buf_full && !pop;

   load_align #(.N(N)) u_align (
      .raw     (ld_raw),
      .offset  (ALUin[1:0]),
      .ld_fmt  (ldFmt),
      .aligned (ld_aligned)
   );

   always_comb begin
      wb_val = ALUin;
      case (wb_sel)
         WB_ALU:  wb_val = ALUin;
         WB_LOAD: wb_val = ld_aligned;
         WB_NPC:  wb_val = NPCin;
         WB_IMM:  wb_val = IMMin;
         default: wb_val = ALUin;
      endcase
   end

   // Storage needs no reset: occupancy is tracked by count alone
   always_ff @(posedge clk) begin
      if (!rst && push_ok) fifo[wr_ptr] <= '{data: loadData, dest: loadDest};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop)     rd_ptr <= ~rd_ptr;
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EXEC;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         err_ovf  <= 1'b0;
         err_tag  <= 1'b0;
      end else begin
         state <= state_nxt;
         rf_we <= retire && cwWB[CW_REGWRITE] && (Rdest_in != 5'd0);
         if (retire) begin
            rf_waddr <= Rdest_in;
            rf_wdata <= wb_val;
         end
         if (overflow) err_ovf <= 1'b1;
         if (retire && is_load && (ld_dest != Rdest_in)) err_tag <= 1'b1;
      end
   end

endmodule
